// File: rtl/gol_pkg.sv
// Shared types, pixel colours and reset pattern for the Game-of-Life engine.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t GRID_RGB  = 24'h270f3f;
    localparam rgb_t ALIVE_RGB = 24'h000000;
    localparam rgb_t DEAD_RGB  = 24'heaeaea;
    localparam rgb_t OFF_RGB   = 24'h000000;

    // i = row, j = column: a block, a vertical blinker and a glider
    function automatic logic seed(input int i, input int j);
        logic s;
        s = (i >= 4 && i <= 5 && j >= 4 && j <= 5);
        s = s || (j == 8 && i >= 8 && i <= 10);
        s = s || (i == 1 && j == 13);
        s = s || (i == 2 && j == 14);
        s = s || (i == 3 && j >= 12 && j <= 14);
        return s;
    endfunction

endpackage

// File: rtl/gol_row_next.sv
// One row of the Life rule: next state of every cell from three board rows.
module gol_row_next #(
    parameter int COLS = 20
) (
    input  logic [COLS-1:0] above_i,
    input  logic [COLS-1:0] mid_i,
    input  logic [COLS-1:0] below_i,
    input  logic            wrap_i,
    output logic [COLS-1:0] next_o
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int L = (c == 0) ? COLS - 1 : c - 1;
        localparam int R = (c == COLS - 1) ? 0 : c + 1;

        logic       le;
        logic       re;
        logic [3:0] cnt;

        // Column neighbours across the board edge only count when wrapping
        assign le = (c != 0) || wrap_i;
        assign re = (c != COLS - 1) || wrap_i;

        assign cnt = 4'(above_i[L] & le) + 4'(above_i[c])
                   + 4'(above_i[R] & re) + 4'(mid_i[L] & le)
                   + 4'(mid_i[R] & re)   + 4'(below_i[L] & le)
                   + 4'(below_i[c])      + 4'(below_i[R] & re);

        assign next_o[c] = (mid_i[c] && cnt == 4'd2) || cnt == 4'd3;
    end

endmodule

// File: rtl/gol_engine.sv
// Game-of-Life engine: row-serial generation into a shadow board,
// atomic commit, host control and a one-cycle pixel renderer.
module gol_engine
    import gol_pkg::*;
#(
    parameter int COLS      = 20,
    parameter int ROWS      = 15,
    parameter int CELL_LOG2 = 5,
    parameter int PERIOD    = 16777216,
    parameter int GEN_W     = 16,
    parameter int COORD_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    step,
    input  logic                    clear,
    input  logic                    wrap,
    input  logic                    cell_wr,
    input  logic [$clog2(COLS)-1:0] cell_wr_x,
    input  logic [$clog2(ROWS)-1:0] cell_wr_y,
    input  logic                    cell_wr_val,
    input  logic [COORD_W-1:0]      x,
    input  logic [COORD_W-1:0]      y,
    output logic [7:0]              r,
    output logic [7:0]              g,
    output logic [7:0]              b,
    output logic                    busy,
    output logic [GEN_W-1:0]        gen_count
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int TW = $clog2(PERIOD);

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    function automatic board_t seed_board();
        board_t bd;
        bd = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                bd[i][j] = seed(i, j);
        return bd;
    endfunction

    localparam board_t SEED = seed_board();

    state_t           state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [RW-1:0]    row_q;
    logic             wrap_q;
    logic             pend_q;
    logic [GEN_W-1:0] gen_q;
    board_t           cur_q;
    board_t           next_q;
    rgb_t             pix_q, pix_d;

    logic tick_last;
    logic idle;
    logic clr_now;
    logic start;
    logic last_row;
    logic wr_ok;

    assign tick_last = tick_q == TW'(PERIOD - 1);
    assign tick_d    = tick_last ? '0 : tick_q + TW'(1);

    // A pending clear is applied in the first idle cycle and beats any start
    assign idle     = state_q == IDLE;
    assign clr_now  = idle && (clear || pend_q);
    assign start    = idle && !clr_now
                   && ((run && tick_last) || (step && !run));
    assign last_row = row_q == RW'(ROWS - 1);
    assign wr_ok    = idle && cell_wr && !clr_now
                   && 32'(cell_wr_x) < COLS
                   && 32'(cell_wr_y) < ROWS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: if (last_row) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb busy = (state_q != IDLE);

    logic [RW-1:0]   up_idx, dn_idx;
    logic [COLS-1:0] above, mid, below, row_nx;

    // Rows beyond the top/bottom edge read as dead unless wrapping
    assign up_idx = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
    assign dn_idx = last_row ? '0 : row_q + RW'(1);
    assign above  = (row_q == '0 && !wrap_q) ? '0 : cur_q[up_idx];
    assign mid    = cur_q[row_q];
    assign below  = (last_row && !wrap_q) ? '0 : cur_q[dn_idx];

    gol_row_next #(
        .COLS(COLS)
    ) u_row (
        .above_i(above),
        .mid_i  (mid),
        .below_i(below),
        .wrap_i (wrap_q),
        .next_o (row_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
            row_q  <= '0;
            wrap_q <= 1'b0;
            pend_q <= 1'b0;
            gen_q  <= '0;
            cur_q  <= SEED;
            next_q <= '0;
        end else begin
            tick_q <= tick_d;
            if (start) begin
                row_q  <= '0;
                wrap_q <= wrap;
            end else if (state_q == COMPUTE) begin
                row_q <= row_q + RW'(1);
            end
            if (state_q == COMPUTE) next_q[row_q] <= row_nx;
            if (busy && clear) pend_q <= 1'b1;
            else if (clr_now)  pend_q <= 1'b0;
            if (clr_now) begin
                cur_q <= '0;
                gen_q <= '0;
            end else if (state_q == COMMIT) begin
                cur_q <= next_q;
                gen_q <= gen_q + GEN_W'(1);
            end else if (wr_ok) begin
                cur_q[cell_wr_y][cell_wr_x] <= cell_wr_val;
            end
        end
    end

    assign gen_count = gen_q;

    logic [COORD_W-1:0] cx, cy;
    logic               on_grid;
    logic               on_board;
    logic               alive;

    assign cx       = x >> CELL_LOG2;
    assign cy       = y >> CELL_LOG2;
    assign on_grid  = (x[CELL_LOG2-1:0] == '0) || (y[CELL_LOG2-1:0] == '0);
    assign on_board = (32'(cx) < COLS) && (32'(cy) < ROWS);
    assign alive    = cur_q[cy[RW-1:0]][cx[CW-1:0]];

    always_comb begin
        pix_d = DEAD_RGB;
        if (on_grid)       pix_d = GRID_RGB;
        else if (!on_board) pix_d = OFF_RGB;
        else if (alive)    pix_d = ALIVE_RGB;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_q <= OFF_RGB;
        else        pix_q <= pix_d;
    end

    assign r = pix_q.r;
    assign g = pix_q.g;
    assign b = pix_q.b;

endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine: pixel vector table, hand sequences and a
// cell-array Life model; the board is read back through the pixel port.
module tb_gol_engine;

    localparam int COLS = 20;
    localparam int ROWS = 15;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       run = 0;
    logic       step = 0;
    logic       clear = 0;
    logic       wrap = 0;
    logic       cell_wr = 0;
    logic [4:0] cell_wr_x = 0;
    logic [3:0] cell_wr_y = 0;
    logic       cell_wr_val = 0;
    logic [9:0] x = 0;
    logic [9:0] y = 0;
    logic [7:0] r, g, b;
    logic       busy;
    logic [15:0] gen_count;

    int checks = 0;
    int errors = 0;
    int gen_exp = 0;
    bit m [ROWS][COLS];

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [23:0] rgb;
        string       nm;
    } vec_t;

    vec_t vt [10];

    always #5 clk = ~clk;

    gol_engine #(.PERIOD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .step       (step),
        .clear      (clear),
        .wrap       (wrap),
        .cell_wr    (cell_wr),
        .cell_wr_x  (cell_wr_x),
        .cell_wr_y  (cell_wr_y),
        .cell_wr_val(cell_wr_val),
        .x          (x),
        .y          (y),
        .r          (r),
        .g          (g),
        .b          (b),
        .busy       (busy),
        .gen_count  (gen_count)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic vec_t mk(input int px, input int py,
                                input logic [23:0] rgb, input string nm);
        vec_t v;
        v.px = 10'(px);
        v.py = 10'(py);
        v.rgb = rgb;
        v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (m[i, j]) m[i][j] = 0;
    endtask

    task automatic model_seed();
        model_clear();
        m[4][4] = 1; m[4][5] = 1; m[5][4] = 1; m[5][5] = 1;
        m[8][8] = 1; m[9][8] = 1; m[10][8] = 1;
        m[1][13] = 1; m[2][14] = 1;
        m[3][12] = 1; m[3][13] = 1; m[3][14] = 1;
    endtask

    task automatic model_gen(input bit w);
        bit nx [ROWS][COLS];
        int n, px, py;
        for (int yy = 0; yy < ROWS; yy++) begin
            for (int xx = 0; xx < COLS; xx++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        px = xx + dx;
                        py = yy + dy;
                        if (w) begin
                            px = (px + COLS) % COLS;
                            py = (py + ROWS) % ROWS;
                        end
                        if ((dx != 0 || dy != 0) && px >= 0 && px < COLS
                            && py >= 0 && py < ROWS)
                            n += int'(m[py][px]);
                    end
                end
                nx[yy][xx] = (n == 3) || (m[yy][xx] && n == 2);
            end
        end
        m = nx;
    endtask

    task automatic read_cell(input int cx, input int cy, output bit alive);
        x = 10'(cx * 32 + 16);
        y = 10'(cy * 32 + 16);
        cyc();
        alive = ({r, g, b} == 24'h000000);
    endtask

    task automatic check_board(input string nm);
        int bad, fx, fy;
        bit a, fa;
        bad = 0; fx = -1; fy = -1; fa = 0;
        for (int cy = 0; cy < ROWS; cy++) begin
            for (int cx = 0; cx < COLS; cx++) begin
                read_cell(cx, cy, a);
                if (a != m[cy][cx]) begin
                    if (bad == 0) begin
                        fx = cx; fy = cy; fa = a;
                    end
                    bad++;
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s %0d cells wrong, first (%0d,%0d) got %0d want %0d",
                     nm, bad, fx, fy, fa, !fa);
        end
    endtask

    task automatic wr(input int cx, input int cy, input bit v);
        cell_wr_x = 5'(cx);
        cell_wr_y = 4'(cy);
        cell_wr_val = v;
        cell_wr = 1;
        cyc();
        cell_wr = 0;
        if (cx < COLS && cy < ROWS) m[cy][cx] = v;
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
        model_clear();
        gen_exp = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic do_step(input bit w, input bit flip, input string nm);
        int n;
        wrap = w;
        step = 1;
        cyc();
        step = 0;
        if (flip) wrap = !w;
        wait_idle(n);
        chk({nm, "_busy_len"}, n, ROWS + 1);
        model_gen(w);
        gen_exp++;
        chk({nm, "_gen"}, gen_count, gen_exp);
    endtask

    task automatic rand_board();
        for (int cy = 0; cy < ROWS; cy++)
            for (int cx = 0; cx < COLS; cx++)
                wr(cx, cy, $urandom_range(2, 0) == 0);
    endtask

    initial begin
        bit a0, a1, a2, a3, a4, a5, a6, a7, a8;
        int n, bad, nchg, since, total;
        logic [15:0] last, g0;

        repeat (3) cyc();
        chk("rst_busy", busy, 0);
        chk("rst_gen", gen_count, 0);
        chk("rst_rgb", {r, g, b}, 24'h0);
        rst_n = 1;
        cyc();
        model_seed();

        vt[0] = mk(32, 40, 24'h270f3f, "pix_grid_x");
        vt[1] = mk(100, 0, 24'h270f3f, "pix_grid_y");
        vt[2] = mk(33, 33, 24'heaeaea, "pix_dead_1_1");
        vt[3] = mk(700, 100, 24'h000000, "pix_off_x");
        vt[4] = mk(144, 144, 24'h000000, "pix_alive_4_4");
        vt[5] = mk(100, 490, 24'h000000, "pix_off_y");
        vt[6] = mk(31, 31, 24'heaeaea, "pix_dead_0_0");
        vt[7] = mk(272, 300, 24'h000000, "pix_alive_8_9");
        vt[8] = mk(639, 479, 24'heaeaea, "pix_dead_19_14");
        vt[9] = mk(640, 479, 24'h270f3f, "pix_grid_640");
        for (int i = 0; i < 10; i++) begin
            x = vt[i].px;
            y = vt[i].py;
            cyc();
            chk(vt[i].nm, {r, g, b}, vt[i].rgb);
        end

        x = 32; y = 40;
        cyc();
        x = 33; y = 33;
        #1;
        chk("pix_latency_hold", {r, g, b}, 24'h270f3f);
        cyc();
        chk("pix_latency_new", {r, g, b}, 24'heaeaea);

        check_board("seed");

        do_step(0, 0, "blink1");
        check_board("blink1");
        read_cell(7, 9, a0); read_cell(8, 9, a1); read_cell(9, 9, a2);
        read_cell(8, 8, a3); read_cell(8, 10, a4);
        chk("blink1_cells", {a0, a1, a2, a3, a4}, 5'b11100);

        do_step(0, 0, "blink2");
        check_board("blink2");
        read_cell(8, 8, a0); read_cell(8, 9, a1); read_cell(8, 10, a2);
        read_cell(7, 9, a3); read_cell(9, 9, a4);
        chk("blink2_cells", {a0, a1, a2, a3, a4}, 5'b11100);

        do_step(0, 0, "gen3");
        do_step(0, 0, "gen4");
        check_board("gen4");
        read_cell(4, 4, a0); read_cell(5, 4, a1);
        read_cell(4, 5, a2); read_cell(5, 5, a3);
        chk("block_still", {a0, a1, a2, a3}, 4'hf);
        read_cell(14, 2, a0); read_cell(15, 3, a1); read_cell(13, 4, a2);
        read_cell(14, 4, a3); read_cell(15, 4, a4);
        read_cell(13, 1, a5); read_cell(12, 3, a6);
        read_cell(13, 3, a7); read_cell(14, 5, a8);
        chk("glider_shift", {a0, a1, a2, a3, a4, a5, a6, a7, a8}, 9'h1f0);

        do_clear();
        chk("clr_gen", gen_count, 0);
        check_board("clr_board");

        wr(19, 7, 1); wr(0, 7, 1); wr(1, 7, 1);
        do_step(1, 1, "wrap1");
        check_board("wrap1");
        read_cell(0, 6, a0); read_cell(0, 7, a1); read_cell(0, 8, a2);
        chk("wrap1_cells", {a0, a1, a2}, 3'b111);

        do_clear();
        wr(19, 7, 1); wr(0, 7, 1); wr(1, 7, 1);
        do_step(0, 1, "nowrap");
        check_board("nowrap_empty");

        wr(25, 3, 1);
        wr(3, 15, 1);
        check_board("wr_range");

        wr(5, 5, 1); wr(6, 5, 1); wr(7, 5, 1);
        clear = 1; step = 1;
        cell_wr = 1; cell_wr_x = 2; cell_wr_y = 2; cell_wr_val = 1;
        cyc();
        clear = 0; step = 0; cell_wr = 0;
        model_clear();
        gen_exp = 0;
        chk("clr_beats_step", busy, 0);
        cyc();
        chk("clr_beats_step_gen", gen_count, 0);
        check_board("clr_wr_step");

        for (int k = 0; k < 4; k++) begin
            rand_board();
            do_step(k % 2 == 1, 0, "rand");
            check_board("rand_board");
        end

        wrap = 0;
        step = 1;
        cyc();
        step = 0;
        cyc();
        clear = 1; cell_wr = 1;
        cell_wr_x = 3; cell_wr_y = 3; cell_wr_val = 1;
        cyc();
        clear = 0; cell_wr = 0;
        wait_idle(n);
        chk("pend_clr_idle", busy, 0);
        cyc();
        model_clear();
        gen_exp = 0;
        chk("pend_clr_gen", gen_count, 0);
        read_cell(3, 3, a0);
        chk("pend_clr_cell33", a0, 0);
        check_board("pend_clr_board");

        rand_board();
        wrap = 1;
        g0 = gen_count;
        last = gen_count;
        bad = 0; nchg = 0; since = 0;
        run = 1;
        for (int c = 0; c < 420; c++) begin
            cyc();
            since++;
            if (gen_count != last) begin
                if (gen_count != 16'(last + 1)) bad++;
                if (busy) bad++;
                if (nchg > 0 && (since < ROWS + 1 || since > ROWS + 5)) bad++;
                nchg++;
                since = 0;
                last = gen_count;
            end
        end
        run = 0;
        wait_idle(n);
        chk("run_drain", busy, 0);
        chk("run_period", bad, 0);
        chk("run_progress", nchg >= 18, 1);
        total = int'(16'(gen_count - g0));
        if (total > 40) total = 40;
        for (int i = 0; i < total; i++) model_gen(1);
        gen_exp += total;
        chk("run_gen", gen_count, gen_exp);
        check_board("run_board");

        wrap = 0;
        step = 1;
        cyc();
        step = 0;
        repeat (5) cyc();
        rst_n = 0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_gen", gen_count, 0);
        chk("rst_mid_rgb", {r, g, b}, 24'h0);
        cyc();
        rst_n = 1;
        model_seed();
        gen_exp = 0;
        check_board("rst_mid_seed");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
